// File: rtl/cam_to_world_if.sv
// Point-in / point-out bus for cam_to_world. Element [0] of each 3-vector is x, [1] y, [2] z.
// The slave modport is the un-projection block; the master is whoever feeds and drains it.
interface cam_to_world_if #(
   parameter int CAM_WIDTH = 20,
   parameter int C_WIDTH   = 18,
   parameter int V_WIDTH   = 16,
   parameter int P_WIDTH   = 16
);
   logic                      valid_in;
   logic                      ready_out;
   logic [2:0][CAM_WIDTH-1:0] cam;
   logic [2:0][C_WIDTH-1:0]   C;
   logic [2:0][V_WIDTH-1:0]   u;
   logic [2:0][V_WIDTH-1:0]   v;
   logic [2:0][V_WIDTH-1:0]   n;
   logic                      valid_out;
   logic                      ready_in;
   logic [2:0][P_WIDTH-1:0]   P;
   logic                      sat_out;

   modport master (
      output valid_in, cam, C, u, v, n, ready_in,
      input  ready_out, valid_out, P, sat_out
   );

   modport slave (
      input  valid_in, cam, C, u, v, n, ready_in,
      output ready_out, valid_out, P, sat_out
   );
endinterface

// File: rtl/cam_to_world.sv
// Camera-space to world-space un-projection: P = C + x*u + y*v + z*n, computed with one
// shared signed multiplier over nine MAC steps, one point per 11 cycles.
module cam_to_world #(
   parameter int CAM_WIDTH = 20,
   parameter int C_WIDTH   = 18,
   parameter int V_WIDTH   = 16,
   parameter int P_WIDTH   = 16,
   parameter int FRAC_BITS = 14
) (
   input  logic          clk,
   input  logic          rst,
   cam_to_world_if.slave io
);
   localparam int ACC_WIDTH  = CAM_WIDTH + V_WIDTH - FRAC_BITS + 3;
   localparam int PROD_WIDTH = CAM_WIDTH + V_WIDTH;
   localparam logic signed [ACC_WIDTH-1:0] P_MAX = ACC_WIDTH'((32'sd1 <<< (P_WIDTH - 1)) - 32'sd1);
   localparam logic signed [ACC_WIDTH-1:0] P_MIN = ~P_MAX;

   typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_e;

   function automatic logic [P_WIDTH-1:0] sat_p(input logic signed [ACC_WIDTH-1:0] val);
      logic [P_WIDTH-1:0] r;
      if (val > P_MAX) begin
         r = P_MAX[P_WIDTH-1:0];
      end else if (val < P_MIN) begin
         r = P_MIN[P_WIDTH-1:0];
      end else begin
         r = val[P_WIDTH-1:0];
      end
      return r;
   endfunction

   state_e                       state_q, state_d;
   logic [3:0]                   step_q, step_d;
   logic [2:0][CAM_WIDTH-1:0]    cam_q, cam_d;
   logic [2:0][C_WIDTH-1:0]      c_q, c_d;
   logic [2:0][V_WIDTH-1:0]      u_q, u_d, v_q, v_d, n_q, n_d;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic [2:0][P_WIDTH-1:0]      p_q, p_d;
   logic                         sat_q, sat_d, sat_out_q, sat_out_d, valid_q, valid_d;

   logic [1:0]                   axis_s, term_s;
   logic signed [CAM_WIDTH-1:0]  mul_a_s;
   logic signed [V_WIDTH-1:0]    mul_b_s;
   logic signed [PROD_WIDTH-1:0] prod_s, prod_shift_s;
   logic signed [ACC_WIDTH-1:0]  term_val_s, base_s, acc_sum_s;
   logic                         clamp_s;

   // Step counter to (axis, term) decode.
   always_comb begin
      axis_s = 2'd0;
      term_s = 2'd0;
      case (step_q)
         4'd0: begin axis_s = 2'd0; term_s = 2'd0; end
         4'd1: begin axis_s = 2'd0; term_s = 2'd1; end
         4'd2: begin axis_s = 2'd0; term_s = 2'd2; end
         4'd3: begin axis_s = 2'd1; term_s = 2'd0; end
         4'd4: begin axis_s = 2'd1; term_s = 2'd1; end
         4'd5: begin axis_s = 2'd1; term_s = 2'd2; end
         4'd6: begin axis_s = 2'd2; term_s = 2'd0; end
         4'd7: begin axis_s = 2'd2; term_s = 2'd1; end
         4'd8: begin axis_s = 2'd2; term_s = 2'd2; end
         default: begin axis_s = 2'd0; term_s = 2'd0; end
      endcase
   end

   // Multiplier operand select: x pairs with u, y with v, z with n.
   always_comb begin
      mul_a_s = '0;
      mul_b_s = '0;
      case (term_s)
         2'd0:    begin mul_a_s = $signed(cam_q[0]); mul_b_s = $signed(u_q[axis_s]); end
         2'd1:    begin mul_a_s = $signed(cam_q[1]); mul_b_s = $signed(v_q[axis_s]); end
         2'd2:    begin mul_a_s = $signed(cam_q[2]); mul_b_s = $signed(n_q[axis_s]); end
         default: begin mul_a_s = '0;                mul_b_s = '0;                end
      endcase
   end

   // Arithmetic shift floors toward -inf; the first term of each axis seeds from C.
   assign prod_s       = mul_a_s * mul_b_s;
   assign prod_shift_s = prod_s >>> FRAC_BITS;
   assign term_val_s   = prod_shift_s[ACC_WIDTH-1:0];
   assign base_s       = (term_s == 2'd0) ? ACC_WIDTH'($signed(c_q[axis_s])) : acc_q;
   assign acc_sum_s    = base_s + term_val_s;
   assign clamp_s      = (acc_sum_s > P_MAX) || (acc_sum_s < P_MIN);

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      cam_d     = cam_q;
      c_d       = c_q;
      u_d       = u_q;
      v_d       = v_q;
      n_d       = n_q;
      acc_d     = acc_q;
      p_d       = p_q;
      sat_d     = sat_q;
      sat_out_d = sat_out_q;
      valid_d   = valid_q;
      case (state_q)
         IDLE: begin
            if (io.valid_in) begin
               cam_d   = io.cam;
               c_d     = io.C;
               u_d     = io.u;
               v_d     = io.v;
               n_d     = io.n;
               step_d  = 4'd0;
               state_d = MAC;
            end else begin
               state_d = IDLE;
            end
         end
         MAC: begin
            acc_d = acc_sum_s;
            if (term_s == 2'd2) begin
               p_d[axis_s] = sat_p(acc_sum_s);
               sat_d       = sat_q | clamp_s;
            end else begin
               sat_d = sat_q;
            end
            if (step_q == 4'd8) begin
               state_d   = DONE;
               valid_d   = 1'b1;
               sat_out_d = sat_q | clamp_s;
            end else begin
               step_d = step_q + 4'd1;
            end
         end
         DONE: begin
            if (io.ready_in) begin
               valid_d = 1'b0;
               sat_d   = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         step_q    <= 4'd0;
         cam_q     <= '0;
         c_q       <= '0;
         u_q       <= '0;
         v_q       <= '0;
         n_q       <= '0;
         acc_q     <= '0;
         p_q       <= '0;
         sat_q     <= 1'b0;
         sat_out_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         cam_q     <= cam_d;
         c_q       <= c_d;
         u_q       <= u_d;
         v_q       <= v_d;
         n_q       <= n_d;
         acc_q     <= acc_d;
         p_q       <= p_d;
         sat_q     <= sat_d;
         sat_out_q <= sat_out_d;
         valid_q   <= valid_d;
      end
   end

   assign io.ready_out = (state_q == IDLE);
   assign io.valid_out = valid_q;
   assign io.P         = p_q;
   assign io.sat_out   = sat_out_q;
endmodule

// File: tb/tb_cam_to_world.sv
// Scoreboard bench for cam_to_world: expected world points are queued when a point is sent
// and popped when valid_out appears.
module tb_cam_to_world;
   localparam int CW = 20;
   localparam int CCW = 18;
   localparam int VW = 16;
   localparam int PW = 16;

   typedef logic [2:0][CW-1:0]  cam3_t;
   typedef logic [2:0][CCW-1:0] c3_t;
   typedef logic [2:0][VW-1:0]  v3_t;
   typedef logic [2:0][PW-1:0]  p3_t;
   typedef struct packed { p3_t p; logic sat; } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cam_to_world_if #(.CAM_WIDTH(CW), .C_WIDTH(CCW), .V_WIDTH(VW), .P_WIDTH(PW)) io ();
   cam_to_world #(.CAM_WIDTH(CW), .C_WIDTH(CCW), .V_WIDTH(VW), .P_WIDTH(PW), .FRAC_BITS(14))
      dut (.clk(clk), .rst(rst), .io(io));

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic cam3_t mk_cam(input int x, input int y, input int z);
      cam3_t r;
      r[0] = x[CW-1:0]; r[1] = y[CW-1:0]; r[2] = z[CW-1:0];
      return r;
   endfunction

   function automatic c3_t mk_c(input int x, input int y, input int z);
      c3_t r;
      r[0] = x[CCW-1:0]; r[1] = y[CCW-1:0]; r[2] = z[CCW-1:0];
      return r;
   endfunction

   function automatic v3_t mk_v(input int x, input int y, input int z);
      v3_t r;
      r[0] = x[VW-1:0]; r[1] = y[VW-1:0]; r[2] = z[VW-1:0];
      return r;
   endfunction

   function automatic exp_t mk_exp(input int x, input int y, input int z, input logic s);
      exp_t e;
      e.p[0] = x[PW-1:0]; e.p[1] = y[PW-1:0]; e.p[2] = z[PW-1:0]; e.sat = s;
      return e;
   endfunction

   // Reference: exact integer math with floor division by 2^14, then clamp to 16 bits.
   function automatic exp_t model(input cam3_t cam, input c3_t c, input v3_t u, input v3_t v, input v3_t n);
      exp_t   e;
      longint s;
      e = '0;
      for (int a = 0; a < 3; a++) begin
         s = longint'($signed(c[a]))
           + ((longint'($signed(cam[0])) * longint'($signed(u[a]))) >>> 14)
           + ((longint'($signed(cam[1])) * longint'($signed(v[a]))) >>> 14)
           + ((longint'($signed(cam[2])) * longint'($signed(n[a]))) >>> 14);
         if (s > 64'sd32767) begin
            s = 64'sd32767; e.sat = 1'b1;
         end else if (s < -64'sd32768) begin
            s = -64'sd32768; e.sat = 1'b1;
         end
         e.p[a] = s[PW-1:0];
      end
      return e;
   endfunction

   task automatic send(input cam3_t cam, input c3_t c, input v3_t u, input v3_t v, input v3_t n);
      int k = 0;
      while (io.ready_out !== 1'b1 && k < 40) begin
         @(posedge clk); #1; k++;
      end
      if (k >= 40) begin
         n_vec++; n_err++;
         $display("FAIL send_ready: ready_out=%b required 1", io.ready_out);
      end
      io.cam = cam; io.C = c; io.u = u; io.v = v; io.n = n;
      io.valid_in = 1'b1;
      @(posedge clk); #1;
      io.valid_in = 1'b0;
      accept_cyc = cyc;
   endtask

   task automatic wait_valid(output int edges);
      edges = 0;
      while (io.valid_out !== 1'b1 && edges < 40) begin
         @(posedge clk); #1; edges++;
      end
   endtask

   task automatic test_reset;
      io.valid_in = 1'b0; io.ready_in = 1'b1;
      io.cam = '0; io.C = '0; io.u = '0; io.v = '0; io.n = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (io.valid_out !== 1'b0 || io.ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL reset_hs: valid_out=%b ready_out=%b required 0 1", io.valid_out, io.ready_out);
      end
      n_vec++;
      if (io.P !== '0 || io.sat_out !== 1'b0) begin
         n_err++;
         $display("FAIL reset_data: P=%h sat_out=%b required 0 0", io.P, io.sat_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_identity;
      int edges;
      exp_t e;
      io.ready_in = 1'b1;
      sb.push_back(mk_exp(103, -50 + 4, 12, 1'b0));
      send(mk_cam(3, 4, 5), mk_c(100, -50, 7), mk_v(16384, 0, 0), mk_v(0, 16384, 0), mk_v(0, 0, 16384));
      wait_valid(edges);
      // valid_out appears after the 9th edge following the accept edge (the 10th edge counting it)
      n_vec++;
      if (edges !== 9) begin
         n_err++;
         $display("FAIL latency: edges=%0d required 9", edges);
      end
      e = sb.pop_front();
      n_vec++;
      if (io.valid_out !== 1'b1 || io.P !== e.p || io.sat_out !== e.sat) begin
         n_err++;
         $display("FAIL identity: valid=%b P=%h sat=%b required 1 P=%h sat=%b", io.valid_out, io.P, io.sat_out, e.p, e.sat);
      end
      @(posedge clk); #1;
      n_vec++;
      if (io.valid_out !== 1'b0 || io.ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL identity_release: valid_out=%b ready_out=%b required 0 1", io.valid_out, io.ready_out);
      end
   endtask

   task automatic test_rotated;
      int edges;
      exp_t e;
      sb.push_back(mk_exp(-4, 3, 5, 1'b0));
      send(mk_cam(3, 4, 5), mk_c(0, 0, 0), mk_v(0, 16384, 0), mk_v(-16384, 0, 0), mk_v(0, 0, 16384));
      wait_valid(edges);
      e = sb.pop_front();
      n_vec++;
      if (io.valid_out !== 1'b1 || io.P !== e.p || io.sat_out !== e.sat) begin
         n_err++;
         $display("FAIL rotated: valid=%b P=%h sat=%b required 1 P=%h sat=%b", io.valid_out, io.P, io.sat_out, e.p, e.sat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_saturation;
      int edges;
      exp_t e;
      sb.push_back(mk_exp(32767, 0, 0, 1'b1));
      send(mk_cam(2000, 0, 0), mk_c(32000, 0, 0), mk_v(16384, 0, 0), mk_v(0, 16384, 0), mk_v(0, 0, 16384));
      wait_valid(edges);
      e = sb.pop_front();
      n_vec++;
      if (io.valid_out !== 1'b1 || io.P !== e.p || io.sat_out !== e.sat) begin
         n_err++;
         $display("FAIL sat_clamp: valid=%b P=%h sat=%b required 1 P=%h sat=%b", io.valid_out, io.P, io.sat_out, e.p, e.sat);
      end
      @(posedge clk); #1;
      sb.push_back(mk_exp(1, 0, 0, 1'b0));
      send(mk_cam(1, 0, 0), mk_c(0, 0, 0), mk_v(16384, 0, 0), mk_v(0, 16384, 0), mk_v(0, 0, 16384));
      wait_valid(edges);
      e = sb.pop_front();
      n_vec++;
      if (io.valid_out !== 1'b1 || io.P !== e.p || io.sat_out !== e.sat) begin
         n_err++;
         $display("FAIL sat_cleared: valid=%b P=%h sat=%b required 1 P=%h sat=%b", io.valid_out, io.P, io.sat_out, e.p, e.sat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_floor;
      int edges;
      exp_t e;
      int xs[2] = '{-3, 3};
      int px[2] = '{-2, 1};
      for (int i = 0; i < 2; i++) begin
         sb.push_back(mk_exp(px[i], 0, 0, 1'b0));
         send(mk_cam(xs[i], 0, 0), mk_c(0, 0, 0), mk_v(8192, 0, 0), mk_v(0, 0, 0), mk_v(0, 0, 0));
         wait_valid(edges);
         e = sb.pop_front();
         n_vec++;
         if (io.valid_out !== 1'b1 || io.P !== e.p || io.sat_out !== e.sat) begin
            n_err++;
            $display("FAIL floor_%0d: valid=%b P=%h sat=%b required 1 P=%h sat=%b", xs[i], io.valid_out, io.P, io.sat_out, e.p, e.sat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      int edges;
      int bad;
      exp_t e;
      io.ready_in = 1'b0;
      sb.push_back(mk_exp(103, -46, 12, 1'b0));
      send(mk_cam(3, 4, 5), mk_c(100, -50, 7), mk_v(16384, 0, 0), mk_v(0, 16384, 0), mk_v(0, 0, 16384));
      wait_valid(edges);
      e = sb.pop_front();
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         io.valid_in = k[0];
         io.cam = mk_cam(k * 7, -k, 900 + k);
         io.C = mk_c(-k * 11, k, 5);
         @(posedge clk); #1;
         if (io.valid_out !== 1'b1 || io.P !== e.p || io.sat_out !== e.sat || io.ready_out !== 1'b0) bad++;
      end
      io.valid_in = 1'b0;
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL bp_hold: unstable cycles=%0d required 0 (P=%h valid=%b ready_out=%b)", bad, io.P, io.valid_out, io.ready_out);
      end
      io.ready_in = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (io.valid_out !== 1'b0 || io.ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: valid_out=%b ready_out=%b required 0 1", io.valid_out, io.ready_out);
      end
      bad = 0;
      repeat (14) begin
         @(posedge clk); #1;
         if (io.valid_out !== 1'b0 || io.ready_out !== 1'b1) bad++;
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL bp_no_second_accept: busy cycles=%0d required 0", bad);
      end
   endtask

   task automatic test_reset_mid;
      int edges;
      int bad;
      exp_t e;
      send(mk_cam(3, 4, 5), mk_c(100, -50, 7), mk_v(16384, 0, 0), mk_v(0, 16384, 0), mk_v(0, 0, 16384));
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++;
      if (io.valid_out !== 1'b0 || io.ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_state: valid_out=%b ready_out=%b required 0 1", io.valid_out, io.ready_out);
      end
      bad = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (io.valid_out !== 1'b0) bad++;
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL midrst_no_pulse: valid cycles=%0d required 0", bad);
      end
      sb.push_back(mk_exp(103, -46, 12, 1'b0));
      send(mk_cam(3, 4, 5), mk_c(100, -50, 7), mk_v(16384, 0, 0), mk_v(0, 16384, 0), mk_v(0, 0, 16384));
      wait_valid(edges);
      e = sb.pop_front();
      n_vec++;
      if (io.valid_out !== 1'b1 || io.P !== e.p || io.sat_out !== e.sat) begin
         n_err++;
         $display("FAIL midrst_rerun: valid=%b P=%h sat=%b required 1 P=%h sat=%b", io.valid_out, io.P, io.sat_out, e.p, e.sat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int edges;
      int prev_cyc;
      exp_t e;
      cam3_t cam;
      c3_t c;
      v3_t u, v, n;
      io.ready_in = 1'b1;
      prev_cyc = 0;
      for (int i = 0; i < 8; i++) begin
         for (int a = 0; a < 3; a++) begin
            cam[a] = CW'(int'($urandom_range(40000, 0)) - 20000);
            c[a]   = CCW'(int'($urandom_range(60000, 0)) - 30000);
            u[a]   = VW'(int'($urandom_range(32768, 0)) - 16384);
            v[a]   = VW'(int'($urandom_range(32768, 0)) - 16384);
            n[a]   = VW'(int'($urandom_range(32768, 0)) - 16384);
         end
         sb.push_back(model(cam, c, u, v, n));
         send(cam, c, u, v, n);
         if (i > 0) begin
            n_vec++;
            if (accept_cyc - prev_cyc !== 11) begin
               n_err++;
               $display("FAIL b2b_period_%0d: period=%0d required 11", i, accept_cyc - prev_cyc);
            end
         end
         prev_cyc = accept_cyc;
         wait_valid(edges);
         e = sb.pop_front();
         n_vec++;
         if (io.valid_out !== 1'b1 || io.P !== e.p || io.sat_out !== e.sat) begin
            n_err++;
            $display("FAIL b2b_%0d: valid=%b P=%h sat=%b required 1 P=%h sat=%b", i, io.valid_out, io.P, io.sat_out, e.p, e.sat);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_identity();
      test_rotated();
      test_saturation();
      test_floor();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
